// File: rtl/fs_seq_ctrl.sv
`default_nettype none
// fs_seq_ctrl: computes a - b - bin one nibble per cycle through a shared
// 4-bit ripple full-subtractor slice, with valid/ready handshakes on both sides.
module fs_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d, diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [3:0]       nib_a, nib_b, nib_d;
  logic             nib_brw;
  logic [WIDTH-1:0] work_upd;

  // Shared 4-bit slice: four chained 1-bit full subtractors on nibble cnt_q.
  always_comb begin : slice
    logic c;
    nib_a    = a_q[{cnt_q, 2'b00} +: 4];
    nib_b    = b_q[{cnt_q, 2'b00} +: 4];
    nib_d    = '0;
    c        = brw_q;
    for (int i = 0; i < 4; i++) begin
      nib_d[i] = nib_a[i] ^ nib_b[i] ^ c;
      c        = (~nib_a[i] & nib_b[i]) | (~(nib_a[i] ^ nib_b[i]) & c);
    end
    nib_brw  = c;
    work_upd = work_q;
    work_upd[{cnt_q, 2'b00} +: 4] = nib_d;
  end

  always_comb begin : fsm
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    work_d    = work_q;
    diff_d    = diff_q;
    brw_d     = brw_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          brw_d   = bin;
          cnt_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = work_upd;
        brw_d  = nib_brw;
        cnt_d  = cnt_q + CW'(1);
        // Last nibble: publish the assembled word in the same edge.
        if (cnt_q == LAST) begin
          diff_d  = work_upd;
          bout_d  = nib_brw;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule
`default_nettype wire

// File: tb/tb_fs_seq_ctrl.sv
`default_nettype none
// tb_fs_seq_ctrl: vector table, hand-written corner sequences and a random
// stall run, all scored against a reference subtraction model.
module tb_fs_seq_ctrl;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, bout, busy;
  logic [W-1:0] diff;

  logic         in_valid8 = 1'b0, out_ready8 = 1'b1, bin8 = 1'b0;
  logic [7:0]   a8 = '0, b8 = '0;
  logic         in_ready8, out_valid8, bout8, busy8;
  logic [7:0]   diff8;

  fs_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .busy(busy)
  );

  fs_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8), .busy(busy8)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected result pushed on accept, popped on output handshake.
  logic [W:0] sb_q[$];
  int         n_acc = 0;
  int         n_res = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb_q.push_back({1'b0, a} - (W+1)'(b) - (W+1)'(bin));
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_res++;
        if (sb_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
        else check("sb_result", 32'({bout, diff}), 32'(sb_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv, output bit ok);
    a = av; b = bv; bin = binv; in_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
    a = ~av; b = ~bv; bin = ~binv;
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
  } vec_t;

  vec_t vecs[8];
  bit   rnd_done = 1'b0;

  initial begin
    bit           ok, seen;
    int           cyc, lat, busy_cnt, acc_before, ov_seen;
    logic [W-1:0] held_d;

    vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0};
    vecs[3] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_diff_bout", 32'({bout, diff}), 32'd0);

    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].bin, ok);
      cyc = 0; lat = -1; busy_cnt = 0; seen = 1'b0;
      while (cyc < 30) begin
        if (out_valid && !seen) begin
          seen = 1'b1;
          lat  = cyc;
          check("vec_diff", 32'(diff), 32'(vecs[v].d));
          check("vec_bout", 32'(bout), 32'(vecs[v].bo));
        end
        if (!busy) break;
        busy_cnt++;
        tick();
        cyc++;
      end
      check("vec_latency", lat, W / 4);
      check("vec_busy_cycles", busy_cnt, W / 4 + 1);
    end

    // Back-pressure with a new request held on the input.
    out_ready = 1'b0;
    issue(16'h1234, 16'h0235, 1'b0, ok);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("bp_out_valid", 32'(out_valid), 32'd1);
    held_d = diff;
    check("bp_first_diff", 32'(held_d), 32'h0FFF);
    a = 16'h0100; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
    acc_before = n_acc;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_stable", 32'({out_valid, in_ready, bout, diff}), 32'({1'b1, 1'b0, 1'b0, held_d}));
    end
    check("bp_no_accept", n_acc, acc_before);
    out_ready = 1'b1;
    tick();
    check("bp_idle_ready", 32'({in_ready, busy}), 32'b10);
    tick();
    in_valid = 1'b0;
    check("bp_accepted", 32'({busy, in_ready}), 32'b10);
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    check("bp_result_drained", sb_q.size(), 0);

    // Asynchronous reset pulse in the second RUN cycle.
    issue(16'h1234, 16'h0235, 1'b0, ok);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", 32'({in_ready, out_valid, busy, bout, diff}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    #4 rst_n = 1'b1;
    n_acc -= sb_q.size();
    sb_q.delete();
    ov_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) ov_seen++;
    end
    check("arst_no_out_valid", ov_seen, 0);
    issue(16'h0010, 16'h0001, 1'b0, ok);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("arst_next_result", 32'({out_valid, bout, diff}), 32'({1'b1, 1'b0, 16'h000F}));
    tick();

    // WIDTH=8 instance.
    a8 = 8'h00; b8 = 8'hFF; bin8 = 1'b1; in_valid8 = 1'b1;
    check("w8_ready", 32'(in_ready8), 32'd1);
    tick();
    in_valid8 = 1'b0;
    cyc = 0;
    while (!out_valid8 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("w8_latency", cyc, 2);
    check("w8_result", 32'({bout8, diff8}), 32'h100);

    // Random operations with input gaps and output stalls.
    fork
      begin
        for (int n = 0; n < 500; n++) begin
          repeat ($urandom_range(0, 2)) tick();
          issue(16'($urandom), 16'($urandom), 1'($urandom), ok);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    check("rnd_drained", sb_q.size(), 0);
    check("rnd_count", n_res, n_acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
